// File: rtl/mult_4b_pkg.sv
// rtl/mult_4b_pkg.sv - shared widths and state encoding for the 4x4 multiplier
// Contents:
//   OP_W      operand width (x, y)
//   RES_W     result width (out)
//   CNT_W     iteration counter width
//   ACC_W     accumulator width (one guard bit above the result)
//   LAST_ITER counter value of the final iteration
//   state_t   FSM state encoding {IDLE, RUN}
package mult_4b_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;
    localparam int CNT_W = 2;
    localparam int ACC_W = RES_W + 1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mult_4b_add9.sv
// rtl/mult_4b_add9.sv - combinational ripple adder for the accumulator update
// Ports:
//   i_a    [ACC_W-1:0]  accumulator
//   i_b    [ACC_W-1:0]  shifted, gated multiplicand
//   o_sum  [ACC_W-1:0]  i_a + i_b (the carry out of the top bit cannot occur)
module mult_4b_add9
    import mult_4b_pkg::*;
(
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum
);

    // Carry into each bit position; nothing is carried out of the MSB because
    // the largest possible result (226) sits well below 2**ACC_W.
    logic [ACC_W-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar g;
    generate
        for (g = 0; g < ACC_W; g++) begin : g_bit
            assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_carry[g];
            if (g < ACC_W - 1) begin : g_carry
                assign w_carry[g+1] = (i_a[g] & i_b[g]) |
                                      (i_a[g] & w_carry[g]) |
                                      (i_b[g] & w_carry[g]);
            end
        end
    endgenerate

endmodule

// File: rtl/mult_4b.sv
// rtl/mult_4b.sv - sequential 4x4 shift-and-add multiplier with carry-in
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_start   request, accepted only while idle
//   i_x       multiplicand [OP_W-1:0]
//   i_y       multiplier   [OP_W-1:0]
//   i_cin     carry-in added to the product
//   o_out     registered result (x*y + cin) [RES_W-1:0]
//   o_cout    registered flag: result does not fit in OP_W bits
//   o_busy    operation in progress
//   o_done    one-cycle pulse when o_out/o_cout update
module mult_4b
    import mult_4b_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [OP_W-1:0]  i_x,
    input  logic [OP_W-1:0]  i_y,
    input  logic             i_cin,
    output logic [RES_W-1:0] o_out,
    output logic             o_cout,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_mcand;
    logic [OP_W-1:0]  r_mplier;
    logic [ACC_W-1:0] r_acc;
    logic [RES_W-1:0] r_out;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_sum;

    // Partial product for this iteration: multiplicand weighted by 2**i,
    // or zero when the corresponding multiplier bit is clear.
    assign w_addend = r_mplier[r_cnt] ? (ACC_W'(r_mcand) << r_cnt) : '0;

    mult_4b_add9 u_add9 (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_cout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_x;
                        r_mplier <= i_y;
                        r_acc    <= {{RES_W{1'b0}}, i_cin};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                    // Outputs are loaded from the adder directly so the final
                    // add and the result update land on the same edge.
                    if (r_cnt == LAST_ITER) begin
                        r_out   <= w_sum[RES_W-1:0];
                        r_cout  <= |w_sum[RES_W-1:OP_W];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out  = r_out;
    assign o_cout = r_cout;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_mult_4b.sv
// tb/tb_mult_4b.sv - scoreboard testbench for mult_4b
module tb_mult_4b;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_x;
    logic [3:0] i_y;
    logic       i_cin;
    logic [7:0] o_out;
    logic       o_cout;
    logic       o_busy;
    logic       o_done;

    typedef struct {
        logic [7:0] out;
        logic       cout;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    mult_4b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_cin   (i_cin),
        .o_out   (o_out),
        .o_cout  (o_cout),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Monitor: every done pops one expectation and checks value and latency.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out",     o_out,  e.out);
                check("cout",    o_cout, e.cout);
                check("latency", cyc,    e.due);
            end
        end
    end

    // Called at a negedge; drives start for exactly one edge.
    task automatic start_op(input logic [3:0] x, input logic [3:0] y, input logic cin,
                            input bit expect_it, input logic [7:0] eo, input logic ec);
        exp_t e;
        i_x = x; i_y = y; i_cin = cin; i_start = 1'b1;
        if (expect_it) begin
            e.out = eo; e.cout = ec; e.due = cyc + 5;
            sb.push_back(e);
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Returns positioned at the negedge where done is visible.
    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 12; k++) begin
            if (o_done) break;
            @(negedge clk);
        end
        if (!o_done) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic cin,
                          input logic [7:0] eo, input logic ec, input string name);
        @(negedge clk);
        start_op(x, y, cin, 1'b1, eo, ec);
        check({name, "_busy"}, o_busy, 1);
        wait_done(name);
        check({name, "_busy_at_done"}, o_busy, 0);
        @(negedge clk);
        check({name, "_done_clears"}, o_done, 0);
        check({name, "_out_holds"}, o_out, eo);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; i_start = 1'b0; i_x = '0; i_y = '0; i_cin = 1'b0;

        // Reset state and start ignored while in reset.
        repeat (2) @(negedge clk);
        check("rst_out",  o_out,  0);
        check("rst_cout", o_cout, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        start_op(4'd15, 4'd15, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_busy) check("start_in_reset", 1, 0);
        end
        check("in_reset_out", o_out, 0);
        rst_n = 1'b1;

        run_op(4'd8,  4'd9, 1'b1, 8'h49, 1'b1, "8x9p1");
        run_op(4'd13, 4'd6, 1'b0, 8'h4E, 1'b1, "13x6");
        run_op(4'd3,  4'd5, 1'b0, 8'h0F, 1'b0, "3x5");
        run_op(4'd3,  4'd5, 1'b1, 8'h10, 1'b1, "3x5p1");
        run_op(4'd0,  4'd0, 1'b1, 8'h01, 1'b0, "0x0p1");

        // 15*15+1 with a stray start mid-run, then back-to-back from the done cycle.
        @(negedge clk);
        start_op(4'd15, 4'd15, 1'b1, 1'b1, 8'hE2, 1'b1);
        start_op(4'd2, 4'd2, 1'b0, 1'b0, 8'h00, 1'b0);
        i_x = 4'd0; i_y = 4'd0; i_cin = 1'b0;
        wait_done("15x15p1");
        check("15x15_out", o_out, 8'hE2);
        start_op(4'd13, 4'd6, 1'b1, 1'b1, 8'h4F, 1'b1);
        check("b2b_busy", o_busy, 1);
        wait_done("b2b");
        check("b2b_out", o_out, 8'h4F);

        // Reset during the second iteration discards the operation.
        @(negedge clk);
        start_op(4'd8, 4'd9, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out",  o_out,  0);
        check("midrst_cout", o_cout, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_idle_busy", o_busy, 0);

        run_op(4'd8, 4'd9, 1'b1, 8'h49, 1'b1, "after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
